// File: rtl/relay_ssp_tx.sv
// relay_ssp_tx: pairs decoded nibbles into bytes, queues them and serialises them MSB-first on SSP.
// Optional feature macro: RELAY_SSP_FLUSH_EN (flushes a lone pending nibble after IDLE_TIMEOUT cycles).
module relay_ssp_tx #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLK_DIV      = 8,
    parameter int unsigned IDLE_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [3:0]               nibble_in,
    input  logic                     nibble_valid,
    output logic                     ssp_clk,
    output logic                     ssp_frame,
    output logic                     ssp_din,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = $clog2(CLK_DIV);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || CLK_DIV < 2 || IDLE_TIMEOUT < 2)
    begin : g_param_check
        $error("relay_ssp_tx: illegal parameter set");
    end

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic           ssp_clk_q, ssp_clk_d;
    logic           frame_q, frame_d;
    logic           din_q, din_d;
    logic [6:0]     sh_q, sh_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [PW-1:0]  level_q, level_d;
    logic           pending_q, pending_d;
    logic [3:0]     high_q, high_d;
    logic           ovf_q, ovf_d;
    logic [7:0]     mem_q [DEPTH];

    logic           rise;
    logic           empty;
    logic           full;
    logic           accept;
    logic           flush;
    logic           push;
    logic           pop;
    logic           wr_en;
    logic [7:0]     push_data;
    logic [7:0]     rd_data;

    // Free-running divider; rise marks the cycle on which ssp_clk goes 0->1.
    always_comb begin
        div_d     = div_q + DW'(1);
        ssp_clk_d = ssp_clk_q;
        if (div_q == DW'(CLK_DIV - 1)) begin
            div_d     = '0;
            ssp_clk_d = ~ssp_clk_q;
        end
    end

    assign rise   = (div_q == DW'(CLK_DIV - 1)) && !ssp_clk_q;
    assign accept = nibble_valid && enable;

`ifdef RELAY_SSP_FLUSH_EN
    localparam int unsigned TW = $clog2(IDLE_TIMEOUT);

    logic [TW-1:0] idle_q, idle_d;

    // Counts cycles since the last accepted nibble, including the strobe cycle itself.
    always_comb begin
        idle_d = idle_q;
        if (accept) begin
            idle_d = TW'(1);
        end else if (pending_q && idle_q != TW'(IDLE_TIMEOUT - 1)) begin
            idle_d = idle_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign flush = enable && pending_q && !accept && (idle_q == TW'(IDLE_TIMEOUT - 1));
`else
    assign flush = 1'b0;
`endif

    // Nibble pairing: first nibble is the high half, second completes the byte.
    always_comb begin
        pending_d = pending_q;
        high_d    = high_q;
        push      = 1'b0;
        push_data = {high_q, nibble_in};
        if (!enable) begin
            pending_d = 1'b0;
        end else if (accept) begin
            if (pending_q) begin
                push      = 1'b1;
                pending_d = 1'b0;
            end else begin
                high_d    = nibble_in;
                pending_d = 1'b1;
            end
        end else if (flush) begin
            push      = 1'b1;
            push_data = {high_q, 4'h0};
            pending_d = 1'b0;
        end
    end

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q == (rd_q ^ {1'b1, {AW{1'b0}}}));
    assign rd_data = mem_q[rd_q[AW-1:0]];
    assign wr_en   = push && (!full || pop);

    // Serialiser: load on a rising edge, then one bit per ssp_clk period.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        din_d    = din_q;
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        pop      = 1'b0;
        if (rise) begin
            if (state_q == ST_SHIFT && bitcnt_q != 3'd0) begin
                bitcnt_d = bitcnt_q - 3'd1;
                din_d    = sh_q[6];
                sh_d     = {sh_q[5:0], 1'b0};
                frame_d  = 1'b0;
            end else if (!empty) begin
                pop      = 1'b1;
                din_d    = rd_data[7];
                sh_d     = rd_data[6:0];
                frame_d  = 1'b1;
                bitcnt_d = 3'd7;
                state_d  = ST_SHIFT;
            end else begin
                state_d  = ST_IDLE;
                din_d    = 1'b0;
                frame_d  = 1'b0;
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        wr_d    = wr_q + PW'(wr_en);
        rd_d    = rd_q + PW'(pop);
        level_d = wr_d - rd_d;
        ovf_d   = ovf_q | (push && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            ssp_clk_q <= 1'b0;
            frame_q   <= 1'b0;
            din_q     <= 1'b0;
            sh_q      <= '0;
            bitcnt_q  <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            pending_q <= 1'b0;
            high_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            ssp_clk_q <= ssp_clk_d;
            frame_q   <= frame_d;
            din_q     <= din_d;
            sh_q      <= sh_d;
            bitcnt_q  <= bitcnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            level_q   <= level_d;
            pending_q <= pending_d;
            high_q    <= high_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    assign ssp_clk    = ssp_clk_q;
    assign ssp_frame  = frame_q;
    assign ssp_din    = din_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_relay_ssp_tx.sv
// Bench for relay_ssp_tx: queue-based reference model plus serial byte monitor, scenario tasks.
module tb_relay_ssp_tx;
    localparam int unsigned DP = 4;
    localparam int unsigned CD = 8;
    localparam int unsigned TO = 16;
    localparam int unsigned LW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          nibble_valid = 1'b0;
    logic [3:0]    nibble_in = 4'h0;
    logic          ssp_clk, ssp_frame, ssp_din, overflow;
    logic [LW-1:0] fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    relay_ssp_tx #(.DEPTH(DP), .CLK_DIV(CD), .IDLE_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .nibble_in    (nibble_in),
        .nibble_valid (nibble_valid),
        .ssp_clk      (ssp_clk),
        .ssp_frame    (ssp_frame),
        .ssp_din      (ssp_din),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    // Reference model: byte queue, cycle count since reset, bit index of the byte on the wire.
    logic [7:0]    m_q[$];
    logic [7:0]    m_acc_log[$];
    int            m_cyc = 0;
    int            m_last_acc = 0;
    int            m_bi = 0;
    int            m_rst_cnt = 0;
    logic          m_pend = 1'b0;
    logic [3:0]    m_high = 4'h0;
    logic [7:0]    m_cur = 8'h00;
    logic          m_busy = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_frame = 1'b0;
    logic          m_din = 1'b0;
    logic          m_sclk = 1'b0;
    logic [LW-1:0] m_lvl = '0;

    wire [6:0] got_vec = {ssp_clk, ssp_frame, ssp_din, fifo_level, overflow};
    wire [6:0] exp_vec = {m_sclk, m_frame, m_din, m_lvl, m_ovf};

    always @(posedge clk) begin
        logic       acc;
        logic       rise;
        logic       have_push;
        logic [7:0] pb;
        if (reset) begin
            m_q.delete();
            m_cyc = 0; m_pend = 0; m_busy = 0; m_ovf = 0; m_frame = 0; m_din = 0; m_bi = 0;
            m_rst_cnt++;
        end else begin
            acc  = nibble_valid && enable;
            rise = (m_cyc % (2 * CD)) == (CD - 1);
            if (rise) begin
                if (m_busy && m_bi < 7) begin
                    m_bi++;
                    m_din = m_cur[7 - m_bi];
                    m_frame = 0;
                end else if (m_q.size() != 0) begin
                    m_cur = m_q.pop_front();
                    m_bi = 0; m_busy = 1; m_frame = 1; m_din = m_cur[7];
                end else begin
                    m_busy = 0; m_frame = 0; m_din = 0;
                end
            end
            have_push = 0;
            pb = 8'h00;
            if (!enable) begin
                m_pend = 0;
            end else if (acc) begin
                if (m_pend) begin
                    pb = {m_high, nibble_in}; have_push = 1; m_pend = 0;
                end else begin
                    m_high = nibble_in; m_pend = 1;
                end
                m_last_acc = m_cyc;
            end
`ifdef RELAY_SSP_FLUSH_EN
            else if (m_pend && (m_cyc - m_last_acc) == int'(TO) - 1) begin
                pb = {m_high, 4'h0}; have_push = 1; m_pend = 0;
            end
`endif
            if (have_push) begin
                if (m_q.size() < DP) begin
                    m_q.push_back(pb);
                    m_acc_log.push_back(pb);
                end else begin
                    m_ovf = 1;
                end
            end
            m_cyc++;
        end
        m_sclk = ((m_cyc / CD) % 2) == 1;
        m_lvl  = LW'(m_q.size());
    end

    // Serial monitor: decodes bytes on ssp_clk falling edges, logs frame start cycles.
    logic [7:0] rx[$];
    int         fr_t[$];
    int         tb_cyc = 0;
    int         rx_cnt = 0;
    int         mon_rst_seen = 0;
    logic [7:0] rx_sh = 8'h00;
    logic       prev_sclk = 1'b0;
    logic       prev_frame = 1'b0;

    always @(negedge clk) begin
        tb_cyc++;
        if (m_rst_cnt != mon_rst_seen) begin
            mon_rst_seen = m_rst_cnt;
            rx_cnt = 0;
        end else begin
            if (ssp_frame === 1'b1 && prev_frame !== 1'b1) fr_t.push_back(tb_cyc);
            if (prev_sclk === 1'b1 && ssp_clk === 1'b0) begin
                if (ssp_frame === 1'b1) begin
                    rx_sh = {7'b0, ssp_din}; rx_cnt = 1;
                end else if (rx_cnt > 0) begin
                    rx_sh = {rx_sh[6:0], ssp_din}; rx_cnt++;
                end
                if (rx_cnt == 8) begin
                    rx.push_back(rx_sh); rx_cnt = 0;
                end
            end
        end
        prev_sclk = ssp_clk;
        prev_frame = ssp_frame;
    end

    task automatic drive(input logic v, input logic e, input logic [3:0] n);
        @(negedge clk);
        nibble_valid = v;
        enable = e;
        nibble_in = n;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (got_vec !== 7'b0) begin
            errors++; $display("FAIL reset_values got=%b exp=%b", got_vec, 7'b0);
        end
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
                errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, got_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_byte();
        int base = rx.size();
        int fr_hi = 0;
        drive(1, 1, 4'hC);
        drive(1, 1, 4'h0);
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++; $display("FAIL single_half_level got=%0d exp=0", fifo_level);
        end
        drive(0, 1, 4'h0);
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++; $display("FAIL single_level got=%0d exp=1", fifo_level);
        end
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
                errors++; $display("FAIL single_cycle cyc=%0d got=%b exp=%b", i, got_vec, exp_vec);
            end
            if (ssp_frame === 1'b1) fr_hi++;
        end
        checks++;
        if (fr_hi != 2 * CD) begin
            errors++; $display("FAIL single_frame_width got=%0d exp=%0d", fr_hi, 2 * CD);
        end
        checks++;
        if (rx.size() != base + 1 || rx[base] !== 8'hC0) begin
            errors++; $display("FAIL single_byte got_n=%0d got=%h exp=c0", rx.size() - base, rx[base]);
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++; $display("FAIL single_drained got=%0d exp=0", fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        int base = rx.size();
        int fb = fr_t.size();
        drive(1, 1, 4'hA);
        drive(1, 1, 4'h5);
        drive(1, 1, 4'h3);
        drive(1, 1, 4'hC);
        drive(0, 1, 4'h0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
                errors++; $display("FAIL b2b_cycle cyc=%0d got=%b exp=%b", i, got_vec, exp_vec);
            end
        end
        checks++;
        if (rx.size() != base + 2 || rx[base] !== 8'hA5 || rx[base + 1] !== 8'h3C) begin
            errors++; $display("FAIL b2b_bytes got_n=%0d got=%h,%h exp=a5,3c", rx.size() - base, rx[base], rx[base + 1]);
        end
        checks++;
        if (fr_t.size() != fb + 2 || (fr_t[fb + 1] - fr_t[fb]) != 16 * CD) begin
            errors++; $display("FAIL b2b_frame_gap got_n=%0d got=%0d exp=%0d", fr_t.size() - fb, fr_t[fb + 1] - fr_t[fb], 16 * CD);
        end
    endtask

    task automatic test_overflow();
        int base = rx.size();
        int guard = 0;
        logic [3:0] nib [12];
        logic [7:0] expb [4];
        for (int i = 0; i < 12; i++) nib[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) expb[i] = {nib[2 * i], nib[2 * i + 1]};
        // Line the burst up right after an ssp_clk rise so no pop lands inside it.
        do begin
            @(negedge clk);
            guard++;
        end while ((m_cyc % (2 * CD)) != (CD - 1) && guard < 64);
        checks++;
        if (guard >= 64) begin
            errors++; $display("FAIL ovf_align_timeout got=%0d exp=<64", guard);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, nib[i]);
            if (i == 8) begin
                checks++;
                if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_full got=%0d/%b exp=4/0", fifo_level, overflow);
                end
            end
        end
        drive(0, 1, 4'h0);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sat got=%0d/%b exp=4/1", fifo_level, overflow);
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
                errors++; $display("FAIL ovf_cycle cyc=%0d got=%b exp=%b", i, got_vec, exp_vec);
            end
        end
        checks++;
        if (rx.size() != base + 4) begin
            errors++; $display("FAIL ovf_count got=%0d exp=4", rx.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx[base + i] !== expb[i]) begin
                errors++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, rx[base + i], expb[i]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int base = rx.size();
        drive(1, 1, 4'hF);
        drive(1, 0, 4'h7);
        drive(0, 1, 4'h0);
        drive(1, 1, 4'h1);
        drive(1, 1, 4'h2);
        drive(0, 1, 4'h0);
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++; $display("FAIL endrop_level got=%0d exp=1", fifo_level);
        end
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
                errors++; $display("FAIL endrop_cycle cyc=%0d got=%b exp=%b", i, got_vec, exp_vec);
            end
        end
        checks++;
        if (rx.size() != base + 1 || rx[base] !== 8'h12) begin
            errors++; $display("FAIL endrop_byte got_n=%0d got=%h exp=12", rx.size() - base, rx[base]);
        end
    endtask

    task automatic test_reset_mid_byte();
        int base = rx.size();
        int guard = 0;
        logic [7:0] b0 = 8'($urandom_range(0, 255));
        logic [7:0] b1 = 8'($urandom_range(0, 255));
        logic [7:0] b2 = 8'($urandom_range(0, 255));
        drive(1, 1, b0[7:4]);
        drive(1, 1, b0[3:0]);
        drive(1, 1, b1[7:4]);
        drive(1, 1, b1[3:0]);
        drive(0, 1, 4'h0);
        while (!(m_busy && m_bi == 4) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 300 || ssp_din !== b0[3]) begin
            errors++; $display("FAIL rstmid_bit3 wait=%0d got=%b exp=%b", guard, ssp_din, b0[3]);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (got_vec !== 7'b0) begin
            errors++; $display("FAIL rstmid_outputs got=%b exp=%b", got_vec, 7'b0);
        end
        reset = 1'b0;
        drive(1, 1, b2[7:4]);
        drive(1, 1, b2[3:0]);
        drive(0, 1, 4'h0);
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
                errors++; $display("FAIL rstmid_cycle cyc=%0d got=%b exp=%b", i, got_vec, exp_vec);
            end
        end
        checks++;
        if (rx.size() != base + 1 || rx[base] !== b2) begin
            errors++; $display("FAIL rstmid_next got_n=%0d got=%h exp=%h", rx.size() - base, rx[base], b2);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int base_rx = rx.size();
            int base_log = m_acc_log.size();
            int guard = 0;
            for (int i = 0; i < 48; i++) begin
                drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)));
                checks++;
                if (got_vec !== exp_vec) begin
                    errors++; $display("FAIL rand_stim r=%0d cyc=%0d got=%b exp=%b", r, i, got_vec, exp_vec);
                end
            end
            drive(0, 0, 4'h0);
            drive(0, 1, 4'h0);
            while ((m_q.size() != 0 || m_busy) && guard < 1000) begin
                @(negedge clk);
                guard++;
                checks++;
                if (got_vec !== exp_vec) begin
                    errors++; $display("FAIL rand_drain r=%0d cyc=%0d got=%b exp=%b", r, guard, got_vec, exp_vec);
                end
            end
            checks++;
            if (guard >= 1000 || rx.size() - base_rx != m_acc_log.size() - base_log) begin
                errors++; $display("FAIL rand_count r=%0d got=%0d exp=%0d", r, rx.size() - base_rx, m_acc_log.size() - base_log);
            end else begin
                for (int i = 0; i < rx.size() - base_rx; i++) begin
                    checks++;
                    if (rx[base_rx + i] !== m_acc_log[base_log + i]) begin
                        errors++; $display("FAIL rand_byte r=%0d i=%0d got=%h exp=%h", r, i, rx[base_rx + i], m_acc_log[base_log + i]);
                    end
                end
            end
        end
    endtask

    task automatic test_flush();
        int base = rx.size();
        drive(1, 1, 4'h9);
        drive(0, 1, 4'h0);
        repeat (14) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++; $display("FAIL flush_early got=%0d exp=0", fifo_level);
        end
        @(negedge clk);
`ifdef RELAY_SSP_FLUSH_EN
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++; $display("FAIL flush_at_timeout got=%0d exp=1", fifo_level);
        end
`else
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++; $display("FAIL flush_absent got=%0d exp=0", fifo_level);
        end
`endif
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checks++;
            if (got_vec !== exp_vec) begin
                errors++; $display("FAIL flush_cycle cyc=%0d got=%b exp=%b", i, got_vec, exp_vec);
            end
        end
`ifdef RELAY_SSP_FLUSH_EN
        checks++;
        if (rx.size() != base + 1 || rx[base] !== 8'h90) begin
            errors++; $display("FAIL flush_byte got_n=%0d got=%h exp=90", rx.size() - base, rx[base]);
        end
`else
        checks++;
        if (rx.size() != base || fifo_level !== 3'd0) begin
            errors++; $display("FAIL flush_none got_n=%0d lvl=%0d exp=0/0", rx.size() - base, fifo_level);
        end
`endif
        drive(0, 0, 4'h0);
        drive(0, 1, 4'h0);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_enable_drop();
        test_reset_mid_byte();
        test_random();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
